// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to the instruction RAM. While idle, core instruction
// fetches pass straight through to the RAM read port. While a load is running,
// core fetches are stalled.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no load running; fetch port passes through to the RAM
// S_COLLECT | accepting bytes of the current word
// S_WRITE   | one-cycle write of the assembled word
// S_DONE    | one-cycle completion pulse, then back to S_IDLE
module imem_loader #(
   parameter int MEM_WORDS = 2048
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [11:0] len_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_ready_o,
   input  logic [11:0] core_addr_i,
   input  logic        core_req_i,
   output logic        core_gnt_o,
   output logic        core_rvalid_o,
   output logic [31:0] core_rdata_o,
   output logic [11:0] mem_addr_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_write_o,
   output logic [10:0] mem_waddr_o,
   output logic [31:0] mem_wdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [11:0] words_o
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   localparam logic [11:0] LP_MAX_LEN = 12'(MEM_WORDS);

   state_t      r_state;
   state_t      w_next;
   logic [11:0] r_len;
   logic [11:0] r_word_cnt;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_word;

   logic [11:0] w_len_clamped;
   logic [11:0] w_cnt_inc;
   logic        w_byte_fire;
   logic        w_idle;

   assign w_len_clamped = (len_i > LP_MAX_LEN) ? LP_MAX_LEN : len_i;
   assign w_cnt_inc     = r_word_cnt + 12'd1;
   assign w_idle        = (r_state == S_IDLE);
   assign w_byte_fire   = (r_state == S_COLLECT) && byte_valid_i;

   // Fetch passthrough in idle; read data always forwarded so a read granted
   // in the start cycle still completes.
   assign mem_addr_o    = core_addr_i;
   assign mem_req_o     = w_idle & core_req_i;
   assign core_gnt_o    = w_idle & mem_gnt_i;
   assign core_rvalid_o = mem_rvalid_i;
   assign core_rdata_o  = mem_rdata_i;

   assign byte_ready_o  = (r_state == S_COLLECT);
   assign mem_write_o   = (r_state == S_WRITE);
   assign mem_waddr_o   = r_word_cnt[10:0];
   assign mem_wdata_o   = r_word;
   assign busy_o        = !w_idle;
   assign done_o        = (r_state == S_DONE);
   assign words_o       = r_word_cnt;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_next = (w_len_clamped == 12'd0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (w_byte_fire && (r_byte_cnt == 2'd3)) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            w_next = (w_cnt_inc == r_len) ? S_DONE : S_COLLECT;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Load datapath: captured length, byte/word counters and word assembly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_len      <= 12'd0;
         r_word_cnt <= 12'd0;
         r_byte_cnt <= 2'd0;
         r_word     <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_len      <= w_len_clamped;
                  r_word_cnt <= 12'd0;
                  r_byte_cnt <= 2'd0;
               end
            end
            S_COLLECT: begin
               if (w_byte_fire) begin
                  r_word[{r_byte_cnt, 3'b000} +: 8] <= byte_i;
                  r_byte_cnt                        <= r_byte_cnt + 2'd1;
               end
            end
            S_WRITE: begin
               r_word_cnt <= w_cnt_inc;
               r_byte_cnt <= 2'd0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
